// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus width and FSM state encodings.
package if_fetch_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 65;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_FULL = 2'd2,
        FS_DROP = 2'd3
    } fs_state_e;

endpackage

// File: rtl/if_fetch_stage_npc_sel.sv
// fs_npc_sel: combinational next-PC priority mux.
// Priority: flush > slot-done branch > pending branch > pc+4.
module if_fetch_stage_npc_sel (
    input  logic        i_flush,
    input  logic [31:0] i_ex_pc,
    input  logic        i_br_now,
    input  logic [31:0] i_br_target,
    input  logic        i_pend,
    input  logic [31:0] i_pend_target,
    input  logic [31:0] i_pc,
    output logic [31:0] o_npc
);

    always_comb begin
        o_npc = i_pc + 32'd4;
        if (i_flush) begin
            o_npc = i_ex_pc;
        end else if (i_br_now) begin
            o_npc = i_br_target;
        end else if (i_pend) begin
            o_npc = i_pend_target;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: one outstanding SRAM-like request, hands {ex, inst, pc} to ID.
// Optional FS_ADEL_CHECK_EN: misaligned fetch addresses become an AdEL bubble instead of a request.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic                       br_valid,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    input  logic                       br_slot_done,
    input  logic                       ws_handle_ex,
    input  logic [31:0]                ex_pc,
    output logic                       inst_req,
    output logic                       inst_wr,
    output logic [1:0]                 inst_size,
    output logic [31:0]                inst_addr,
    output logic [31:0]                inst_wdata,
    input  logic                       inst_addr_ok,
    input  logic                       inst_data_ok,
    input  logic [31:0]                inst_rdata,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    fs_state_e   r_state;
    logic [31:0] r_npc;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_br_pend;
    logic [31:0] r_br_target;

    logic        w_br_now;
    logic        w_pend_set;
    logic        w_redirect;
    logic        w_deliver;
    logic        w_addr_hs;
    logic        w_adel;
    logic        w_fs_ex;
    logic [31:0] w_npc_next;

    assign w_br_now   = br_valid & br_taken & br_slot_done & ~ws_handle_ex;
    assign w_pend_set = br_valid & br_taken & ~br_slot_done & ~ws_handle_ex;
    assign w_redirect = ws_handle_ex | w_br_now;
    assign w_deliver  = (r_state == FS_FULL) & ds_allowin;
    assign w_addr_hs  = inst_req & inst_addr_ok;

`ifdef FS_ADEL_CHECK_EN
    logic r_ex;
    assign w_adel  = |r_npc[1:0];
    assign w_fs_ex = r_ex;
`else
    assign w_adel  = 1'b0;
    assign w_fs_ex = 1'b0;
`endif

    // A branch leaving ID in the delivery cycle makes the delivered word its delay slot.
    if_fetch_stage_npc_sel u_npc_sel (
        .i_flush       (ws_handle_ex),
        .i_ex_pc       (ex_pc),
        .i_br_now      (w_br_now),
        .i_br_target   (br_target),
        .i_pend        (r_br_pend | w_pend_set),
        .i_pend_target (w_pend_set ? br_target : r_br_target),
        .i_pc          (r_pc),
        .o_npc         (w_npc_next)
    );

    assign inst_req       = resetn & (r_state == FS_REQ) & ~w_adel;
    assign inst_wr        = 1'b0;
    assign inst_size      = 2'b10;
    assign inst_addr      = r_npc;
    assign inst_wdata     = 32'd0;
    assign fs_to_ds_valid = (r_state == FS_FULL);
    assign fs_to_ds_bus   = {w_fs_ex, r_inst, r_pc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= FS_REQ;
            r_npc       <= RESET_PC;
            r_pc        <= 32'd0;
            r_inst      <= 32'd0;
            r_br_pend   <= 1'b0;
            r_br_target <= 32'd0;
`ifdef FS_ADEL_CHECK_EN
            r_ex        <= 1'b0;
`endif
        end else begin
            if (w_redirect || w_deliver) begin
                r_npc     <= w_npc_next;
                r_br_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_br_pend   <= 1'b1;
                r_br_target <= br_target;
            end

            unique case (r_state)
                FS_REQ: begin
                    if (w_redirect) begin
                        // An accepted request for the stale address must still be drained.
                        if (w_addr_hs) r_state <= FS_DROP;
                    end else if (w_adel) begin
                        r_state <= FS_FULL;
                        r_pc    <= r_npc;
                        r_inst  <= 32'd0;
`ifdef FS_ADEL_CHECK_EN
                        r_ex    <= 1'b1;
`endif
                    end else if (w_addr_hs) begin
                        r_state <= FS_WAIT;
                        r_pc    <= r_npc;
`ifdef FS_ADEL_CHECK_EN
                        r_ex    <= 1'b0;
`endif
                    end
                end
                FS_WAIT: begin
                    if (inst_data_ok) begin
                        r_state <= w_redirect ? FS_REQ : FS_FULL;
                        r_inst  <= inst_rdata;
                    end else if (w_redirect) begin
                        r_state <= FS_DROP;
                    end
                end
                FS_FULL: begin
                    if (w_redirect || ds_allowin) r_state <= FS_REQ;
                end
                FS_DROP: begin
                    if (inst_data_ok) r_state <= FS_REQ;
                end
                default: r_state <= FS_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of expected {ex, inst, pc} deliveries.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_allowin = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        br_slot_done = 1'b0;
    logic        ws_handle_ex = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [64:0] exp_q[$];
    logic [31:0] last_addr;

    if_fetch_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .br_slot_done   (br_slot_done),
        .ws_handle_ex   (ws_handle_ex),
        .ex_pc          (ex_pc),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_accept(input logic [31:0] addr);
        for (int i = 0; i < 16 && !inst_req; i++) cyc();
        check("req_valid", {64'd0, inst_req}, 65'd1);
        check("req_addr", {33'd0, inst_addr}, {33'd0, addr});
        last_addr = addr;
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
    endtask

    task automatic data_return(input logic [31:0] rdata, input bit keep);
        inst_data_ok = 1'b1;
        inst_rdata   = rdata;
        if (keep) exp_q.push_back({1'b0, rdata, last_addr});
        cyc();
        inst_data_ok = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input bit keep);
        req_accept(addr);
        data_return(rdata, keep);
        check("latency_valid", {64'd0, fs_to_ds_valid}, 65'd1);
    endtask

    // Hand the FULL word to ID, optionally with a branch leaving ID in the same cycle.
    task automatic deliver(input bit bv, input bit bt, input logic [31:0] tgt);
        logic [64:0] exp;
        for (int i = 0; i < 16 && !fs_to_ds_valid; i++) cyc();
        check("deliver_valid", {64'd0, fs_to_ds_valid}, 65'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'bx;
        check("deliver_bus", fs_to_ds_bus, exp);
        ds_allowin   = 1'b1;
        br_valid     = bv;
        br_taken     = bt;
        br_target    = tgt;
        br_slot_done = 1'b0;
        cyc();
        ds_allowin = 1'b0;
        br_valid   = 1'b0;
        br_taken   = 1'b0;
    endtask

    task automatic flush(input logic [31:0] pc);
        ws_handle_ex = 1'b1;
        ex_pc        = pc;
        cyc();
        ws_handle_ex = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        check("rst_req", {64'd0, inst_req}, 65'd0);
        check("rst_valid", {64'd0, fs_to_ds_valid}, 65'd0);
        check("rst_bus", fs_to_ds_bus, 65'd0);
        resetn = 1'b1;
        check("tied_wr", {64'd0, inst_wr}, 65'd0);
        check("tied_size", {63'd0, inst_size}, 65'd2);
        check("tied_wdata", {33'd0, inst_wdata}, 65'd0);

        // 1: first fetch from reset PC
        fetch(32'hbfc00000, 32'h24010001, 1'b1);
        deliver(1'b0, 1'b0, 32'd0);
        check("t1_next_addr", {33'd0, inst_addr}, {33'd0, 32'hbfc00004});

        // 2: flush while WAIT, stale data dropped
        req_accept(32'hbfc00004);
        flush(32'hbfc00380);
        check("t2_drop_req", {64'd0, inst_req}, 65'd0);
        data_return(32'hdeadbeef, 1'b0);
        check("t2_drop_valid", {64'd0, fs_to_ds_valid}, 65'd0);
        check("t2_redir_addr", {33'd0, inst_addr}, {33'd0, 32'hbfc00380});
        fetch(32'hbfc00380, 32'h00000001, 1'b1);
        deliver(1'b0, 1'b0, 32'd0);

        // 3: flush in REQ, then taken branch with delay slot still in flight
        flush(32'hbfc00008);
        check("t3_req_stay", {64'd0, inst_req}, 65'd1);
        req_accept(32'hbfc00008);
        br_valid = 1'b1; br_taken = 1'b1; br_slot_done = 1'b0; br_target = 32'hbfc00100;
        cyc();
        br_valid = 1'b0; br_taken = 1'b0;
        data_return(32'h00000000, 1'b1);
        deliver(1'b0, 1'b0, 32'd0);
        check("t3_target", {33'd0, inst_addr}, {33'd0, 32'hbfc00100});

        // 4: slot-done branch kills the FULL word
        fetch(32'hbfc00100, 32'h11111111, 1'b1);
        deliver(1'b0, 1'b0, 32'd0);
        fetch(32'hbfc00104, 32'h22222222, 1'b0);
        br_valid = 1'b1; br_taken = 1'b1; br_slot_done = 1'b1; br_target = 32'hbfc00200;
        cyc();
        br_valid = 1'b0; br_taken = 1'b0; br_slot_done = 1'b0;
        check("t4_valid_drop", {64'd0, fs_to_ds_valid}, 65'd0);
        check("t4_target", {33'd0, inst_addr}, {33'd0, 32'hbfc00200});

        // 5: flush and branch together, flush wins and no branch stays pending
        req_accept(32'hbfc00200);
        br_valid = 1'b1; br_taken = 1'b1; br_slot_done = 1'b0; br_target = 32'hbfc00500;
        flush(32'hbfc00380);
        br_valid = 1'b0; br_taken = 1'b0;
        data_return(32'hbadbad00, 1'b0);
        check("t5_valid", {64'd0, fs_to_ds_valid}, 65'd0);
        check("t5_addr", {33'd0, inst_addr}, {33'd0, 32'hbfc00380});
        fetch(32'hbfc00380, 32'h33333333, 1'b1);
        deliver(1'b0, 1'b0, 32'd0);
        check("t5_no_pend", {33'd0, inst_addr}, {33'd0, 32'hbfc00384});

        // Branch leaving ID in the delivery cycle: delivered word is its delay slot
        fetch(32'hbfc00384, 32'h44444444, 1'b1);
        deliver(1'b1, 1'b1, 32'hbfc00600);
        check("dlv_br_target", {33'd0, inst_addr}, {33'd0, 32'hbfc00600});

        // pc+4 wraps
        flush(32'hfffffffc);
        fetch(32'hfffffffc, 32'h55555555, 1'b1);
        deliver(1'b0, 1'b0, 32'd0);
        check("wrap_addr", {33'd0, inst_addr}, 65'd0);

        // Not-taken branch in the delivery cycle is ignored
        fetch(32'h00000000, 32'h66666666, 1'b1);
        deliver(1'b1, 1'b0, 32'hbfc00700);
        check("nt_addr", {33'd0, inst_addr}, {33'd0, 32'h00000004});

        // 6: misaligned fetch address
        flush(32'hbfc00102);
`ifdef FS_ADEL_CHECK_EN
        check("adel_no_req", {64'd0, inst_req}, 65'd0);
        cyc();
        check("adel_valid", {64'd0, fs_to_ds_valid}, 65'd1);
        check("adel_bus", fs_to_ds_bus, {1'b1, 32'd0, 32'hbfc00102});
`else
        check("mis_req", {64'd0, inst_req}, 65'd1);
        check("mis_addr", {33'd0, inst_addr}, {33'd0, 32'hbfc00102});
`endif

        check("sb_empty", 65'(exp_q.size()), 65'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
